// File: rtl/ram_16k_if.sv
// Hack data-memory bus: CPU side drives address/in/load, memory returns out.
interface ram_16k_if #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 14
);
   logic [DATA_WIDTH-1:0] in;
   logic [ADDR_WIDTH-1:0] address;
   logic                  load;
   logic [DATA_WIDTH-1:0] out;

   modport master (output in, output address, output load, input out);
   modport slave  (input in, input address, input load, output out);
endinterface

// File: rtl/ram_16k.sv
// 16K x 16 Hack data memory built from four 4K banks selected by the two
// address MSBs. Combinational read, rising-edge write, async clear of all words.

// One bank: combinational read port, single synchronous write port.
module ram_16k_bank #(
   parameter int DATA_WIDTH = 16,
   parameter int OFF_WIDTH  = 12
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  we,
   input  logic [OFF_WIDTH-1:0]  offset,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] rdata
);
   localparam int DEPTH = 2**OFF_WIDTH;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // Reset clears every word at once; otherwise write the addressed word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (we) begin
         mem[offset] <= wdata;
      end
   end

   // Zero-latency read; a write only becomes visible after its edge.
   assign rdata = mem[offset];
endmodule

module ram_16k #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 14
) (
   input  logic      clk,
   input  logic      rst_n,
   ram_16k_if.slave  bus
);
   localparam int SEL_WIDTH = 2;
   localparam int NUM_BANKS = 2**SEL_WIDTH;
   localparam int OFF_WIDTH = ADDR_WIDTH - SEL_WIDTH;

   logic [SEL_WIDTH-1:0]                  sel;
   logic [OFF_WIDTH-1:0]                  offset;
   logic [NUM_BANKS-1:0][DATA_WIDTH-1:0]  bank_rdata;

   assign sel    = bus.address[ADDR_WIDTH-1 -: SEL_WIDTH];
   assign offset = bus.address[OFF_WIDTH-1:0];

   // Load is demuxed to the selected bank only, so the others never see a write.
   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      ram_16k_bank #(
         .DATA_WIDTH (DATA_WIDTH),
         .OFF_WIDTH  (OFF_WIDTH)
      ) u_bank (
         .clk    (clk),
         .rst_n  (rst_n),
         .we     (bus.load && (sel == SEL_WIDTH'(b))),
         .offset (offset),
         .wdata  (bus.in),
         .rdata  (bank_rdata[b])
      );
   end

   assign bus.out = bank_rdata[sel];
endmodule

// File: tb/tb_ram_16k.sv
// Directed bench for ram_16k: a table of {address, in, load, expected out
// before the edge} vectors, plus hand sequences for in-cycle timing and reset.
module tb_ram_16k;
   logic clk = 1'b0;
   logic rst_n;
   int   n_checks = 0;
   int   n_fail   = 0;

   ram_16k_if #(.DATA_WIDTH(16), .ADDR_WIDTH(14)) bus ();

   ram_16k #(.DATA_WIDTH(16), .ADDR_WIDTH(14)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [13:0] addr;
      logic [15:0] din;
      logic        ld;
      logic [15:0] exp;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input logic [13:0] a, input logic [15:0] d,
                               input logic l, input logic [15:0] e);
      vec_t v;
      v.addr = a; v.din = d; v.ld = l; v.exp = e;
      vecs.push_back(v);
   endfunction

   task automatic check(input string name, input logic [15:0] exp);
      n_checks++;
      if (bus.out !== exp) begin
         n_fail++;
         $display("FAIL %s: addr=%h out=%h expected=%h", name, bus.address, bus.out, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // reset sweep
      add(14'h0000, 16'h0000, 1'b0, 16'h0000);
      add(14'h0001, 16'h0000, 1'b0, 16'h0000);
      add(14'h0002, 16'h0000, 1'b0, 16'h0000);
      add(14'h0FFF, 16'h0000, 1'b0, 16'h0000);
      add(14'h1000, 16'h0000, 1'b0, 16'h0000);
      add(14'h3FFF, 16'h0000, 1'b0, 16'h0000);
      // basic write/read
      add(14'h0002, 16'hBEEF, 1'b1, 16'h0000);
      add(14'h0002, 16'h0000, 1'b0, 16'hBEEF);
      add(14'h0001, 16'h0000, 1'b0, 16'h0000);
      add(14'h0002, 16'h0000, 1'b0, 16'hBEEF);
      // bank boundaries
      add(14'h0FFF, 16'h1111, 1'b1, 16'h0000);
      add(14'h1000, 16'h2222, 1'b1, 16'h0000);
      add(14'h2FFF, 16'h3333, 1'b1, 16'h0000);
      add(14'h3000, 16'h4444, 1'b1, 16'h0000);
      add(14'h3FFF, 16'h5555, 1'b1, 16'h0000);
      add(14'h0FFF, 16'h0000, 1'b0, 16'h1111);
      add(14'h1000, 16'h0000, 1'b0, 16'h2222);
      add(14'h2FFF, 16'h0000, 1'b0, 16'h3333);
      add(14'h3000, 16'h0000, 1'b0, 16'h4444);
      add(14'h3FFF, 16'h0000, 1'b0, 16'h5555);
      add(14'h0FFE, 16'h0000, 1'b0, 16'h0000);
      add(14'h1001, 16'h0000, 1'b0, 16'h0000);
      // same offset in other banks must not alias
      add(14'h1FFF, 16'h0000, 1'b0, 16'h0000);
      add(14'h2000, 16'h0000, 1'b0, 16'h0000);
      // load = 0 edges change nothing
      add(14'h0005, 16'hFFFF, 1'b0, 16'h0000);
      add(14'h0005, 16'hFFFF, 1'b0, 16'h0000);
      add(14'h0005, 16'hFFFF, 1'b0, 16'h0000);
      add(14'h0005, 16'h0000, 1'b0, 16'h0000);
      // overwrite
      add(14'h0007, 16'h0001, 1'b1, 16'h0000);
      add(14'h0007, 16'h8000, 1'b1, 16'h0001);
      add(14'h0007, 16'h0000, 1'b0, 16'h8000);
      // prime word 9 for the timing sequence
      add(14'h0009, 16'hAAAA, 1'b1, 16'h0000);
      add(14'h0009, 16'h0000, 1'b0, 16'hAAAA);

      rst_n       = 1'b0;
      bus.in      = '0;
      bus.address = '0;
      bus.load    = 1'b0;
      #2;
      check("reset_hold", 16'h0000);
      #98;
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         bus.address = vecs[i].addr;
         bus.in      = vecs[i].din;
         bus.load    = vecs[i].ld;
         #1;
         check($sformatf("vec%0d", i), vecs[i].exp);
         tick();
      end

      // read-during-write timing and mid-cycle address change
      bus.address = 14'd9; bus.in = 16'h5555; bus.load = 1'b1;
      #1; check("rdw_old", 16'hAAAA);
      bus.address = 14'd2;
      #1; check("addr_change", 16'hBEEF);
      bus.address = 14'd9;
      #1; check("addr_back", 16'hAAAA);
      tick();
      bus.load = 1'b0;
      #1; check("rdw_new", 16'h5555);

      // async reset between edges
      bus.address = 14'h0FFF;
      #1; check("pre_reset", 16'h1111);
      rst_n = 1'b0;
      #1; check("async_clear", 16'h0000);
      bus.address = 14'd9; bus.in = 16'h1234; bus.load = 1'b1;
      tick();
      check("write_in_reset", 16'h0000);
      bus.load = 1'b0;
      #2;
      rst_n = 1'b1;
      foreach (vecs[i]) begin
         if (vecs[i].ld) begin
            bus.address = vecs[i].addr;
            #1; check($sformatf("post_reset_%h", vecs[i].addr), 16'h0000);
         end
      end
      bus.address = 14'd9;
      #1; check("post_reset_9", 16'h0000);

      // first edge after release performs a write
      tick();
      bus.address = 14'd3; bus.in = 16'h00C3; bus.load = 1'b1;
      tick();
      bus.load = 1'b0;
      #1; check("write_after_release", 16'h00C3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/ram_16k.md
Name: ram_16k

Overview:
- 16K x 16-bit read/write data memory for the Hack computer. It sits between the CPU data path (addressM/inM/writeM) and the memory-map decoder.
- Hack chip semantics: combinational read of the addressed word; synchronous write on the rising clock edge when load is high.
- Organised as four 4K banks selected by address[13:12].

Parameters:
- DATA_WIDTH, 16, word width in bits.
- ADDR_WIDTH, 14, address width; depth = 2**ADDR_WIDTH = 16384 words.

Ports:
- clk  input  1  system clock; all writes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset; clears the entire memory contents.
- in  input  16  write data.
- address  input  14  word address for both read and write.
- load  input  1  write enable, active high.
- out  output  16  read data = contents of word[address].

Behaviour:
- Storage: 16384 words x 16 bits, word index = address (0..16383), no wrap or aliasing. Bank = address[13:12]; offset within bank = address[11:0].
- Reset: while rst_n = 0, every word reads 0 and out = 0 regardless of address. The clear is immediate, with no clock required.
- Reset is asynchronous on assertion. Deassertion is sampled by the design: the first clock edge at which rst_n = 1 may perform a write.
- After reset and until written, every word reads 0x0000.
- Read: out is a combinational function of address and current contents, with zero-cycle latency. A change on address updates out in the same cycle, with no clock needed.
- Write: on posedge clk with rst_n = 1 and load = 1, word[address] <= in. Exactly one word changes; the other 16383 words are untouched.
- With load = 0, an edge changes nothing.
- Read-during-write: before the edge, out shows the old word[address]. After the edge, out shows the newly written value (read-after-write on the next cycle). No write-through bypass of in to out.
- Load gating: load is routed only to the selected bank (demux on address[13:12]). out is muxed from the selected bank.
- Reset during write: rst_n = 0 overrides load. A write at an edge while rst_n = 0 is discarded, and contents stay 0.
- X handling: the values of in and address are don't-care when load = 0. address must be stable around the edge when load = 1.
- No handshake, no back-pressure, and no error outputs.

Test Plan:
- Reset: rst_n = 0 for 100 ns, then sweep address 0, 1, 2, 4095, 4096, 16383 with load = 0 -> out = 0x0000 at each address.
- Write/read: address = 2, in = 0xBEEF, load = 1 for one edge, then load = 0. address = 2 -> out = 0xBEEF. address = 1 -> out = 0x0000. Back to address = 2 -> 0xBEEF.
- Bank boundaries: write 0x1111 @0x0FFF, 0x2222 @0x1000, 0x3333 @0x2FFF, 0x4444 @0x3000, 0x5555 @0x3FFF. Read each back -> exact values; neighbouring addresses 0x0FFE and 0x1001 read 0.
- Load = 0 edge: address = 5, in = 0xFFFF, load = 0 across several edges -> out at address 5 stays 0x0000. Overwrite: write 0x0001 then 0x8000 to address 7 -> out = 0x8000.
- Timing: with word 9 = 0xAAAA, set in = 0x5555, load = 1, address = 9. Before the edge out = 0xAAAA; after the edge out = 0x5555. Changing address mid-cycle updates out without a clock.
- Async reset mid-operation: after several writes, pulse rst_n low between edges -> out drops to 0 immediately. Hold load = 1 with in = 0x1234 across an edge during reset -> the write is ignored. After release, all previously written addresses read 0.
